// File: rtl/round_robin_fifo_distributor_if.sv
// Bundle between the single producer, the four per-channel readers and the distributor.
interface round_robin_fifo_distributor_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [3:0]        ren;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [3:0]        valid;
    logic [3:0]        full;
    logic [3:0]        empty;
    logic [1:0]        ptr;

    modport master (
        output din, din_valid, ren,
        input  din_ready, a, b, c, d, valid, full, empty, ptr
    );

    modport slave (
        input  din, din_valid, ren,
        output din_ready, a, b, c, d, valid, full, empty, ptr
    );
endinterface

// File: rtl/round_robin_fifo_distributor.sv
// Splits one input word stream across four circular FIFOs in strict a,b,c,d order;
// each channel is drained independently by its own reader.
module round_robin_fifo_distributor #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    round_robin_fifo_distributor_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [1:0] ptr_q;
    logic [3:0] full_v;
    logic [3:0] empty_v;
    logic [3:0] valid_v;
    logic       accept;

    // Ready only looks at registered full flags, never at this cycle's ren.
    assign bus.din_ready = !full_v[ptr_q];
    assign accept        = bus.din_valid && !full_v[ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (accept) begin
            ptr_q <= ptr_q + 2'd1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     wp;
        logic [AW-1:0]     rp;
        logic [CW-1:0]     cnt;
        logic [CW-1:0]     cnt_nxt;
        logic [DATA_W-1:0] rdata;
        logic              valid_q;
        logic              full_q;
        logic              empty_q;
        logic              wr;
        logic              rd;

        assign wr = accept && (ptr_q == 2'(i));
        assign rd = bus.ren[i] && !empty_q;

        always_comb begin
            cnt_nxt = cnt;
            if (wr && !rd) begin
                cnt_nxt = cnt + CW'(1);
            end else if (!wr && rd) begin
                cnt_nxt = cnt - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (wr) begin
                mem[wp] <= bus.din;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp      <= '0;
                rp      <= '0;
                cnt     <= '0;
                full_q  <= 1'b0;
                empty_q <= 1'b1;
                rdata   <= '0;
                valid_q <= 1'b0;
            end else begin
                if (wr) begin
                    wp <= wp + AW'(1);
                end
                if (rd) begin
                    rp <= rp + AW'(1);
                end
                cnt     <= cnt_nxt;
                full_q  <= (cnt_nxt == CW'(DEPTH));
                empty_q <= (cnt_nxt == CW'(0));
                rdata   <= rd ? mem[rp] : '0;
                valid_q <= rd;
            end
        end

        assign full_v[i]  = full_q;
        assign empty_v[i] = empty_q;
        assign valid_v[i] = valid_q;
    end

    assign bus.a     = g_ch[0].rdata;
    assign bus.b     = g_ch[1].rdata;
    assign bus.c     = g_ch[2].rdata;
    assign bus.d     = g_ch[3].rdata;
    assign bus.valid = valid_v;
    assign bus.full  = full_v;
    assign bus.empty = empty_v;
    assign bus.ptr   = ptr_q;
endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// Directed bench for the round-robin distributor with a per-channel queue model.
module tb_round_robin_fifo_distributor;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [DATA_W-1:0] q [4][$];
    int                mptr;
    string             phase;

    round_robin_fifo_distributor_if #(.DATA_W(DATA_W)) bus ();

    round_robin_fifo_distributor #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s %s: observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        logic [3:0] ef;
        logic [3:0] ee;
        for (int i = 0; i < 4; i++) begin
            ef[i] = (q[i].size() == DEPTH);
            ee[i] = (q[i].size() == 0);
        end
        check("ptr", 32'(bus.ptr), 32'(mptr));
        check("full", 32'(bus.full), 32'(ef));
        check("empty", 32'(bus.empty), 32'(ee));
    endtask

    // One clock: drive inputs, predict, advance to just after the edge, compare.
    task automatic step(input bit dv, input logic [DATA_W-1:0] d, input logic [3:0] r);
        logic [3:0]        ev;
        logic [DATA_W-1:0] ed [4];
        logic [DATA_W-1:0] outs [4];
        bit                rdy;
        bus.din_valid = dv;
        bus.din       = d;
        bus.ren       = r;
        #1;
        rdy = (q[mptr].size() != DEPTH);
        check("din_ready", 32'(bus.din_ready), 32'(rdy));
        for (int i = 0; i < 4; i++) begin
            if (r[i] && q[i].size() > 0) begin
                ev[i] = 1'b1;
                ed[i] = q[i].pop_front();
            end else begin
                ev[i] = 1'b0;
                ed[i] = '0;
            end
        end
        if (dv && rdy) begin
            q[mptr].push_back(d);
            mptr = (mptr + 1) % 4;
        end
        @(posedge clk);
        #1;
        outs[0] = bus.a;
        outs[1] = bus.b;
        outs[2] = bus.c;
        outs[3] = bus.d;
        check("valid", 32'(bus.valid), 32'(ev));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("data ch%0d", i), 32'(outs[i]), 32'(ed[i]));
        end
        check_flags();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mptr   = 0;
        phase  = "reset";
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.ren       = 4'b0000;
        #3;
        check("valid", 32'(bus.valid), 32'h0);
        check("a", 32'(bus.a), 32'h0);
        check("din_ready", 32'(bus.din_ready), 32'h1);
        check_flags();
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        phase = "basic";
        step(1'b1, 8'd87, 4'b0000);
        step(1'b1, 8'd56, 4'b0000);
        step(1'b1, 8'd9,  4'b0000);
        step(1'b1, 8'd13, 4'b0000);
        step(1'b0, 8'd0,  4'b1111);

        phase = "fill";
        for (int i = 0; i < 33; i++) begin
            step(1'b1, DATA_W'(100 + i), 4'b0000);
        end

        phase = "stall_pop";
        step(1'b1, 8'd200, 4'b0001);
        step(1'b1, 8'd200, 4'b0000);
        step(1'b0, 8'd0,   4'b0000);

        phase = "drain_a";
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'd0, 4'b0001);
        end
        phase = "empty_read";
        step(1'b0, 8'd0, 4'b0001);
        step(1'b0, 8'd0, 4'b0001);

        phase = "drain_all";
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'd0, 4'b1111);
        end

        phase = "stream";
        for (int i = 0; i < 40; i++) begin
            step(1'b1, DATA_W'(7 * i + 3), 4'b1111);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 4'b1111);
        end

        phase = "mid_reset";
        step(1'b1, 8'd50, 4'b0000);
        step(1'b1, 8'd51, 4'b0010);
        bus.din_valid = 1'b1;
        bus.din       = 8'd52;
        bus.ren       = 4'b1111;
        #3;
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.ren       = 4'b0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
        end
        mptr = 0;
        check("valid", 32'(bus.valid), 32'h0);
        check("a", 32'(bus.a), 32'h0);
        check("b", 32'(bus.b), 32'h0);
        check("c", 32'(bus.c), 32'h0);
        check("d", 32'(bus.d), 32'h0);
        check("din_ready", 32'(bus.din_ready), 32'h1);
        check_flags();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        phase = "after_reset";
        step(1'b1, 8'd61, 4'b0000);
        step(1'b1, 8'd62, 4'b0000);
        step(1'b0, 8'd0,  4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
